dds_pwm_dac_driver: RTL and testbench
=====================================

Name: dds_pwm_dac_driver

Overview:
Downstream stage of the phase-to-amplitude converter. It consumes 10-bit unsigned sine samples (midscale 100, span 0..200) through a valid/ready handshake and converts each one into one pulse-width-modulated frame on a single output pin, for an external RC-filter DAC. The block double-buffers samples so that duty changes happen only at frame boundaries, and it reports clipping and starvation through sticky flags.

Parameters:
DATA_W, 10, sample width.
PERIOD, 200, counts per PWM frame; a sample value equal to PERIOD gives 100 % duty.
PRESCALE, 1, clk cycles per PWM count (must be >= 1).

Ports:
clk  in  1  system clock, rising edge.
reset_n  in  1  reset, asynchronous and active-low; applies to all state.
enable  in  1  run request.
sample_in  in  DATA_W  amplitude sample from the phase-to-amplitude converter.
sample_valid  in  1  sample_in is valid this cycle.
sample_ready  out  1  holding register is empty; a sample is accepted when valid && ready.
clr_flags  in  1  synchronous clear of the sticky flags.
pwm_out  out  1  registered PWM output.
frame_start  out  1  one-cycle pulse on the first clk of each frame.
clip_flag  out  1  sticky: an accepted sample exceeded PERIOD.
underrun_flag  out  1  sticky: a frame boundary found the holding register empty.
busy  out  1  state is RUN or DRAIN.

Behaviour:
- Reset values:
  - state=IDLE, pre_cnt=0, cnt=0, duty=PERIOD/2 (100), hold_full=0.
  - pwm_out=0, frame_start=0, clip_flag=0, underrun_flag=0, busy=0, sample_ready=1.
- Counters:
  - pre_cnt runs 0..PRESCALE-1; a tick occurs when pre_cnt==PRESCALE-1.
  - cnt is $clog2(PERIOD+1) bits wide. It advances on each tick and wraps from PERIOD-1 to 0.
  - A frame boundary is a tick with cnt==PERIOD-1, or the IDLE->RUN transition.
- Input handshake:
  - sample_ready = !hold_full, driven straight from a register with no combinational path from sample_valid.
  - On accept: hold <= min(sample_in, PERIOD) and hold_full <= 1. If sample_in > PERIOD, clip_flag <= 1.
  - Samples are accepted in every state, including IDLE.
- Boundary load:
  - If hold_full: duty <= hold and hold_full <= 0.
  - Otherwise: duty is unchanged (the previous sample repeats) and underrun_flag <= 1. No underrun is flagged on the IDLE->RUN transition.
  - An accept in the same cycle as a boundary with the holding register empty goes into hold; it is not bypassed into duty and waits for the next boundary.
  - When hold is full, ready is 0, so no accept can coincide with a load.
- PWM:
  - In RUN and DRAIN, pwm_out is registered so that it is high exactly while (cnt < duty) for the count currently held.
  - duty=0 gives a constant low output; duty=PERIOD gives a constant high output.
  - Frame length is PERIOD*PRESCALE clk cycles.
  - pwm_out is 0 in IDLE.
- frame_start: pulses in the first clk of each frame (cnt==0, pre_cnt==0) in RUN or DRAIN.
- FSM:
  - IDLE: if enable, go to RUN with cnt=0, pre_cnt=0 and a boundary load.
  - RUN: if !enable, go to DRAIN.
  - DRAIN: if enable, return to RUN with no disturbance to counters or output. At the end of the frame (tick with cnt==PERIOD-1), go to IDLE; pwm_out=0, cnt=0, and duty keeps its last value.
- Flags:
  - clr_flags clears both sticky flags.
  - If a set event occurs in the same cycle as clr_flags, the set wins.
- Reset mid-frame forces all outputs to their reset values immediately; no partial frame completes.

Test Plan:
1. Reset while enable=1 and mid-frame -> pwm_out=0, busy=0, sample_ready=1 immediately. After release with enable=0: IDLE, duty=100.
2. PRESCALE=1, accept 50, then enable -> frame_start every 200 cycles, and pwm_out high 50 / low 150 cycles in every frame.
3. Samples 0, 200, 250 fed one per frame -> frames are all-low, then all-high, then all-high. clip_flag=1 only after the 250 is accepted.
4. Feed one sample, then withhold sample_valid for one frame -> underrun_flag=1 and the previous duty repeats. Pulse clr_flags -> flag returns to 0.
5. Hold sample_valid high with changing data -> ready goes low after the first accept and reasserts one cycle after each boundary. Exactly one sample is consumed per frame.
6. Deassert enable at cnt=80 -> the frame completes through cnt=199, then pwm_out=0 and busy=0. Re-asserting enable during DRAIN keeps the output continuous with no extra frame_start.

Source files
------------

// File: rtl/dds_pwm_dac_driver.sv
// PWM DAC driver: converts each accepted sine sample into one PWM frame.
// Samples are double-buffered so duty only changes on frame boundaries.
module dds_pwm_dac_driver #(
    parameter int unsigned DATA_W   = 10,
    parameter int unsigned PERIOD   = 200,
    parameter int unsigned PRESCALE = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    output logic              sample_ready,
    input  logic              clr_flags,
    output logic              pwm_out,
    output logic              frame_start,
    output logic              clip_flag,
    output logic              underrun_flag,
    output logic              busy
);
    localparam int unsigned CNT_W = $clog2(PERIOD + 1);
    localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] DUTY_FULL = CNT_W'(PERIOD);
    localparam logic [CNT_W-1:0] DUTY_MID  = CNT_W'(PERIOD / 2);
    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(PRESCALE - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] duty_q, duty_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic             pwm_q, pwm_d;
    logic             frame_start_q, frame_start_d;
    logic             clip_q, clip_d;
    logic             underrun_q, underrun_d;

    logic             accept;
    logic             sample_over;
    logic             tick;
    logic             boundary;
    logic             running_d;

    always_comb begin
        state_d     = state_q;
        pre_cnt_d   = pre_cnt_q;
        cnt_d       = cnt_q;
        duty_d      = duty_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        clip_d      = clr_flags ? 1'b0 : clip_q;
        underrun_d  = clr_flags ? 1'b0 : underrun_q;
        boundary    = 1'b0;
        tick        = (pre_cnt_q == PRE_LAST);
        accept      = sample_valid && !hold_full_q;
        sample_over = (32'(sample_in) > PERIOD);

        if (accept) begin
            hold_d      = sample_over ? DUTY_FULL : CNT_W'(sample_in);
            hold_full_d = 1'b1;
            if (sample_over) begin
                clip_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d   = ST_RUN;
                    cnt_d     = '0;
                    pre_cnt_d = '0;
                    boundary  = 1'b1;
                end
            end
            ST_RUN, ST_DRAIN: begin
                if (state_q == ST_DRAIN && enable) begin
                    state_d = ST_RUN;
                end else if (state_q == ST_RUN && !enable) begin
                    state_d = ST_DRAIN;
                end
                if (tick) begin
                    pre_cnt_d = '0;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        // A drain that is still disabled at frame end stops here without loading.
                        if (state_q == ST_DRAIN && !enable) begin
                            state_d = ST_IDLE;
                        end else begin
                            boundary = 1'b1;
                            if (!hold_full_q) begin
                                underrun_d = 1'b1;
                            end
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    pre_cnt_d = pre_cnt_q + PRE_W'(1);
                end
            end
            default: begin
                state_d   = ST_IDLE;
                cnt_d     = '0;
                pre_cnt_d = '0;
            end
        endcase

        if (boundary && hold_full_q) begin
            duty_d      = hold_q;
            hold_full_d = 1'b0;
        end

        // Outputs are computed from next-state values so the register matches the count it accompanies.
        running_d     = (state_d == ST_RUN) || (state_d == ST_DRAIN);
        pwm_d         = running_d && (cnt_d < duty_d);
        frame_start_d = running_d && (cnt_d == '0) && (pre_cnt_d == '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            pre_cnt_q     <= '0;
            cnt_q         <= '0;
            duty_q        <= DUTY_MID;
            hold_q        <= '0;
            hold_full_q   <= 1'b0;
            pwm_q         <= 1'b0;
            frame_start_q <= 1'b0;
            clip_q        <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pre_cnt_q     <= pre_cnt_d;
            cnt_q         <= cnt_d;
            duty_q        <= duty_d;
            hold_q        <= hold_d;
            hold_full_q   <= hold_full_d;
            pwm_q         <= pwm_d;
            frame_start_q <= frame_start_d;
            clip_q        <= clip_d;
            underrun_q    <= underrun_d;
        end
    end

    assign sample_ready  = !hold_full_q;
    assign pwm_out       = pwm_q;
    assign frame_start   = frame_start_q;
    assign clip_flag     = clip_q;
    assign underrun_flag = underrun_q;
    assign busy          = (state_q == ST_RUN) || (state_q == ST_DRAIN);

endmodule

// File: tb/tb_dds_pwm_dac_driver.sv
// Directed bench for dds_pwm_dac_driver: table of per-frame samples plus
// hand-written sequences for reset, underrun, back-pressure and drain.
module tb_dds_pwm_dac_driver;
    localparam int PERIOD = 200;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       enable;
    logic [9:0] sample_in;
    logic       sample_valid;
    logic       sample_ready;
    logic       clr_flags;
    logic       pwm_out;
    logic       frame_start;
    logic       clip_flag;
    logic       underrun_flag;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dds_pwm_dac_driver #(
        .DATA_W(10),
        .PERIOD(200),
        .PRESCALE(1)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .enable(enable),
        .sample_in(sample_in),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .clr_flags(clr_flags),
        .pwm_out(pwm_out),
        .frame_start(frame_start),
        .clip_flag(clip_flag),
        .underrun_flag(underrun_flag),
        .busy(busy)
    );

    typedef struct {
        logic [9:0] sample;
        int         exp_hi;
        int         exp_clip;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out (t=%0t)", nm, $time);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [9:0] v);
        int n = 0;
        sample_in    = v;
        sample_valid = 1'b1;
        while (!sample_ready && n < 400) begin
            cyc();
            n++;
        end
        if (!sample_ready) timeout_fail("send");
        cyc();
        sample_valid = 1'b0;
    endtask

    task automatic wait_fs();
        int n = 0;
        while (!frame_start && n < 400) begin
            cyc();
            n++;
        end
        if (!frame_start) timeout_fail("wait_frame_start");
    endtask

    // Runs one frame from its frame_start cycle, optionally offering a sample in cycle 0.
    task automatic run_frame(input logic do_send, input logic [9:0] val,
                             output int hi, output int fs, output logic acc);
        hi  = 0;
        fs  = 0;
        acc = 1'b0;
        for (int i = 0; i < PERIOD; i++) begin
            hi += int'(pwm_out);
            fs += int'(frame_start);
            if (i == 0 && do_send) begin
                sample_in    = val;
                sample_valid = 1'b1;
                if (sample_ready) acc = 1'b1;
            end else begin
                sample_valid = 1'b0;
            end
            cyc();
        end
        sample_valid = 1'b0;
    endtask

    initial begin
        int         hi;
        int         fs;
        int         prev_hi;
        int         busy_lo;
        int         acc_cnt;
        int         gc;
        int         frame_acc[3];
        logic       acc;

        vecs[0] = '{sample: 10'd0,   exp_hi: 0,   exp_clip: 0};
        vecs[1] = '{sample: 10'd200, exp_hi: 200, exp_clip: 0};
        vecs[2] = '{sample: 10'd250, exp_hi: 200, exp_clip: 1};
        vecs[3] = '{sample: 10'd137, exp_hi: 137, exp_clip: 1};
        vecs[4] = '{sample: 10'd1,   exp_hi: 1,   exp_clip: 1};
        vecs[5] = '{sample: 10'd199, exp_hi: 199, exp_clip: 1};

        reset_n      = 1'b0;
        enable       = 1'b0;
        sample_in    = '0;
        sample_valid = 1'b0;
        clr_flags    = 1'b0;
        repeat (3) cyc();
        chk("rst_pwm", int'(pwm_out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(sample_ready), 1);
        chk("rst_fs", int'(frame_start), 0);
        chk("rst_clip", int'(clip_flag), 0);
        chk("rst_underrun", int'(underrun_flag), 0);
        reset_n = 1'b1;
        repeat (2) cyc();

        // Accept in IDLE, then start: 50-high frames, then repeat on underrun.
        send(10'd50);
        chk("idle_accept_ready", int'(sample_ready), 0);
        chk("idle_busy", int'(busy), 0);
        enable = 1'b1;
        cyc();
        chk("start_fs", int'(frame_start), 1);
        chk("start_busy", int'(busy), 1);
        chk("start_ready", int'(sample_ready), 1);
        chk("start_no_underrun", int'(underrun_flag), 0);
        run_frame(1'b0, '0, hi, fs, acc);
        chk("f50_hi", hi, 50);
        chk("f50_fs", fs, 1);
        chk("underrun_set", int'(underrun_flag), 1);
        run_frame(1'b0, '0, hi, fs, acc);
        chk("repeat_hi", hi, 50);
        clr_flags = 1'b1;
        cyc();
        clr_flags = 1'b0;
        chk("underrun_clr", int'(underrun_flag), 0);
        send(10'd50);
        wait_fs();
        chk("underrun_stays_clr", int'(underrun_flag), 0);

        prev_hi = 50;
        for (int i = 0; i <= 6; i++) begin
            if (i < 6) run_frame(1'b1, vecs[i].sample, hi, fs, acc);
            else       run_frame(1'b0, '0, hi, fs, acc);
            chk($sformatf("vec%0d_hi", i), hi, prev_hi);
            chk($sformatf("vec%0d_fs", i), fs, 1);
            if (i < 6) begin
                chk($sformatf("vec%0d_acc", i), int'(acc), 1);
                chk($sformatf("vec%0d_clip", i), int'(clip_flag), vecs[i].exp_clip);
                prev_hi = vecs[i].exp_hi;
            end
        end
        chk("vec_end_underrun", int'(underrun_flag), 1);

        // Continuous valid with changing data: one accept per frame.
        acc_cnt = 0;
        gc = 0;
        frame_acc = '{0, 0, 0};
        sample_valid = 1'b1;
        for (int f = 0; f < 3; f++) begin
            hi = 0;
            for (int i = 0; i < PERIOD; i++) begin
                hi += int'(pwm_out);
                if (i == 0) chk($sformatf("bp%0d_ready_hi", f), int'(sample_ready), 1);
                if (i == 1) chk($sformatf("bp%0d_ready_lo", f), int'(sample_ready), 0);
                sample_in = 10'(10 + (gc % 190));
                clr_flags = (f == 0 && i == 0);
                if (sample_ready) begin
                    acc_cnt++;
                    frame_acc[f] = int'(sample_in);
                end
                gc++;
                cyc();
            end
            if (f == 0) chk("bp0_hi", hi, 199);
            else        chk($sformatf("bp%0d_hi", f), hi, frame_acc[f-1]);
        end
        sample_valid = 1'b0;
        clr_flags    = 1'b0;
        chk("bp_accepts", acc_cnt, 3);
        chk("bp_underrun", int'(underrun_flag), 0);

        // Drain: disable at cnt=80, frame completes, then idle.
        run_frame(1'b1, 10'd120, hi, fs, acc);
        chk("pre_drain_hi", hi, frame_acc[2]);
        chk("pre_drain_acc", int'(acc), 1);
        hi = 0;
        for (int i = 0; i < PERIOD; i++) begin
            hi += int'(pwm_out);
            if (i == 80) enable = 1'b0;
            if (i == 199) chk("drain_busy_end", int'(busy), 1);
            cyc();
        end
        chk("drain_hi", hi, 120);
        chk("drain_idle_busy", int'(busy), 0);
        chk("drain_idle_pwm", int'(pwm_out), 0);
        chk("drain_idle_fs", int'(frame_start), 0);
        chk("drain_no_underrun", int'(underrun_flag), 0);
        repeat (3) cyc();
        chk("idle_pwm", int'(pwm_out), 0);

        // Restart keeps last duty; re-enable during drain is seamless.
        enable = 1'b1;
        cyc();
        chk("restart_fs", int'(frame_start), 1);
        chk("restart_no_underrun", int'(underrun_flag), 0);
        hi = 0;
        fs = 0;
        busy_lo = 0;
        for (int i = 0; i < PERIOD; i++) begin
            hi += int'(pwm_out);
            fs += int'(frame_start);
            busy_lo += int'(!busy);
            if (i == 50)  enable = 1'b0;
            if (i == 100) enable = 1'b1;
            cyc();
        end
        chk("redrain_hi", hi, 120);
        chk("redrain_fs", fs, 1);
        chk("redrain_busy_lo", busy_lo, 0);
        chk("redrain_next_fs", int'(frame_start), 1);
        chk("redrain_underrun", int'(underrun_flag), 1);

        // clr_flags colliding with an underrun event: the set wins.
        clr_flags = 1'b1;
        cyc();
        clr_flags = 1'b0;
        chk("clr2", int'(underrun_flag), 0);
        repeat (198) cyc();
        clr_flags = 1'b1;
        cyc();
        clr_flags = 1'b0;
        chk("set_wins_fs", int'(frame_start), 1);
        chk("set_wins", int'(underrun_flag), 1);

        // Asynchronous reset mid-frame with enable high and a sample pending.
        sample_in    = 10'd77;
        sample_valid = 1'b1;
        cyc();
        sample_valid = 1'b0;
        repeat (9) cyc();
        chk("pre_rst_pwm", int'(pwm_out), 1);
        chk("pre_rst_ready", int'(sample_ready), 0);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_pwm", int'(pwm_out), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_ready", int'(sample_ready), 1);
        chk("arst_clip", int'(clip_flag), 0);
        chk("arst_underrun", int'(underrun_flag), 0);
        enable = 1'b0;
        repeat (3) cyc();
        reset_n = 1'b1;
        repeat (2) cyc();
        chk("post_rst_busy", int'(busy), 0);
        enable = 1'b1;
        cyc();
        chk("post_rst_fs", int'(frame_start), 1);
        run_frame(1'b0, '0, hi, fs, acc);
        chk("post_rst_duty_mid", hi, 100);
        chk("post_rst_frame_fs", fs, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
